// File: rtl/layer_desc_decoder_seq_if.sv
// Purpose: groups the descriptor input handshake, the abort strobe and the
//          decoded-result output handshake of layer_desc_decoder_seq.
// Modports:
//   master - descriptor producer / result consumer (controller side)
//   slave  - the decoder itself
// Signals:
//   flush_i                        synchronous abort
//   in_valid_i / in_ready_o        descriptor handshake
//   layer_type_i .. pass_i         descriptor fields
//   out_valid_o / out_ready_i      result handshake
//   layer_type_o .. err_code_o     decoded control parameters
interface layer_desc_decoder_seq_if #(
  parameter int DIM_W  = 8,
  parameter int CH_W   = 11,
  parameter int N_W    = 16,
  parameter int PASS_W = 140
);
  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [1:0]        layer_type_i;
  logic [2:0]        k_i;
  logic [1:0]        stride_i;
  logic [DIM_W-1:0]  in_R_i;
  logic [DIM_W-1:0]  in_C_i;
  logic [CH_W-1:0]   in_D_i;
  logic [CH_W-1:0]   out_K_i;
  logic [1:0]        pad_T_i;
  logic [1:0]        pad_B_i;
  logic [1:0]        pad_L_i;
  logic [1:0]        pad_R_i;
  logic [PASS_W-1:0] pass_i;

  logic              out_valid_o;
  logic              out_ready_i;
  logic [1:0]        layer_type_o;
  logic [2:0]        kH_o;
  logic [2:0]        kW_o;
  logic [1:0]        stride_o;
  logic [CH_W-1:0]   in_D_o;
  logic [CH_W-1:0]   out_K_o;
  logic [DIM_W:0]    padded_R_o;
  logic [DIM_W:0]    padded_C_o;
  logic [DIM_W-1:0]  out_R_o;
  logic [DIM_W-1:0]  out_C_o;
  logic [7:0]        tile_D_o;
  logic [7:0]        tile_K_o;
  logic [7:0]        tile_D_f_o;
  logic [7:0]        tile_K_f_o;
  logic [N_W-1:0]    tile_n_o;
  logic [PASS_W-1:0] pass_o;
  logic              err_o;
  logic [1:0]        err_code_o;

  modport master (
    output flush_i, in_valid_i, layer_type_i, k_i, stride_i, in_R_i, in_C_i,
           in_D_i, out_K_i, pad_T_i, pad_B_i, pad_L_i, pad_R_i, pass_i,
           out_ready_i,
    input  in_ready_o, out_valid_o, layer_type_o, kH_o, kW_o, stride_o,
           in_D_o, out_K_o, padded_R_o, padded_C_o, out_R_o, out_C_o,
           tile_D_o, tile_K_o, tile_D_f_o, tile_K_f_o, tile_n_o, pass_o,
           err_o, err_code_o
  );

  modport slave (
    input  flush_i, in_valid_i, layer_type_i, k_i, stride_i, in_R_i, in_C_i,
           in_D_i, out_K_i, pad_T_i, pad_B_i, pad_L_i, pad_R_i, pass_i,
           out_ready_i,
    output in_ready_o, out_valid_o, layer_type_o, kH_o, kW_o, stride_o,
           in_D_o, out_K_o, padded_R_o, padded_C_o, out_R_o, out_C_o,
           tile_D_o, tile_K_o, tile_D_f_o, tile_K_f_o, tile_n_o, pass_o,
           err_o, err_code_o
  );
endinterface

// File: rtl/layer_desc_decoder_seq.sv
// Purpose: multi-cycle layer descriptor decoder. Captures one descriptor per
//          handshake, derives padded dims, floor-stride output dims and the
//          GLB-bounded tile count using one shared restoring divider, then
//          presents the decoded parameters under a valid/ready handshake.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset
//   bus   - slave side of layer_desc_decoder_seq_if (descriptor in,
//           flush, decoded result out)
module layer_desc_decoder_seq #(
  parameter int GLB_BYTES  = 65536,
  parameter int BYTES_I    = 1,
  parameter int BYTES_W    = 1,
  parameter int BYTES_P    = 2,
  parameter int DIM_W      = 8,
  parameter int CH_W       = 11,
  parameter int TILE_PW    = 32,
  parameter int TILE_DW    = 10,
  parameter int TILE_STD   = 10,
  parameter int DIV_W      = 24,
  parameter int N_W        = 16,
  parameter int MAX_TILE_N = 255,
  parameter int PASS_W     = 140
) (
  input logic                     clk,
  input logic                     rst_n,
  layer_desc_decoder_seq_if.slave bus
);

  localparam int PD_W  = DIM_W + 1;
  localparam int CNT_W = $clog2(DIV_W + 1);

  localparam logic [1:0] T_PW  = 2'd0;
  localparam logic [1:0] T_DW  = 2'd1;
  localparam logic [1:0] T_STD = 2'd2;

  localparam logic [31:0]    DIV_MAX  = 32'((64'd1 << DIV_W) - 64'd1);
  localparam logic [DIV_W:0] DIM_MAX  = (DIV_W+1)'((1 << DIM_W) - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PREP, S_DIV_R, S_DIV_C, S_FOOT, S_DIV_N, S_DONE
  } state_t;

  state_t state, state_n;

  // Captured descriptor
  logic [1:0]        cap_type;
  logic [2:0]        cap_k;
  logic [1:0]        cap_stride;
  logic [DIM_W-1:0]  cap_in_r, cap_in_c;
  logic [CH_W-1:0]   cap_in_d, cap_out_k;
  logic [1:0]        cap_pad_t, cap_pad_b, cap_pad_l, cap_pad_r;
  logic [PASS_W-1:0] cap_pass;

  // Intermediate results
  logic [DIM_W-1:0]  work_out_r, work_out_c;

  // Shared divider
  logic [DIV_W:0]    div_rem;
  logic [DIV_W-1:0]  div_quo;
  logic [DIV_W-1:0]  div_dvsr;
  logic [CNT_W-1:0]  div_cnt;

  // Output registers
  logic [1:0]        r_type, r_stride, r_err_code;
  logic [2:0]        r_k;
  logic [CH_W-1:0]   r_in_d, r_out_k;
  logic [PD_W-1:0]   r_pad_r, r_pad_c;
  logic [DIM_W-1:0]  r_out_r, r_out_c;
  logic [7:0]        r_tile_d, r_tile_k, r_tile_d_f, r_tile_k_f;
  logic [N_W-1:0]    r_tile_n;
  logic [PASS_W-1:0] r_pass;
  logic              r_err;

  // Combinational decode of the captured descriptor
  logic [2:0]        k_eff;
  logic [7:0]        tile_d, tile_k, tile_d_f, tile_k_f;
  logic [PD_W-1:0]   padded_r, padded_c;
  logic [31:0]       w_bytes, row_bytes;
  logic [DIV_W-1:0]  row_dvsr;
  logic              prep_err;
  logic [1:0]        prep_code;
  logic              accept, load_err, load_ok;

  logic [DIV_W:0]    div_shift, div_rem_nxt, quo_plus1;
  logic [DIV_W-1:0]  div_quo_nxt;
  logic              div_ge, div_last;
  logic [DIM_W-1:0]  dim_from_quo;
  logic [N_W-1:0]    tile_n_calc;

  always_comb begin
    k_eff    = ((cap_type == T_DW) || (cap_type == T_STD)) ? cap_k : 3'd1;
    tile_d   = 8'(TILE_PW);
    tile_k   = 8'(TILE_PW);
    tile_d_f = 8'(TILE_PW);
    tile_k_f = 8'(TILE_PW);
    case (cap_type)
      T_DW: begin
        tile_d   = 8'(TILE_DW);
        tile_k   = 8'(TILE_DW);
        tile_d_f = 8'd1;
        tile_k_f = 8'(TILE_DW);
      end
      T_STD: begin
        tile_d   = 8'(TILE_STD);
        tile_k   = 8'(TILE_STD);
        tile_d_f = 8'(TILE_STD);
        tile_k_f = 8'(TILE_STD);
      end
      default: ;
    endcase

    padded_r = PD_W'(cap_in_r) + PD_W'(cap_pad_t) + PD_W'(cap_pad_b);
    padded_c = PD_W'(cap_in_c) + PD_W'(cap_pad_l) + PD_W'(cap_pad_r);

    w_bytes  = 32'(BYTES_W) * 32'(tile_k_f) * 32'(tile_d_f)
             * 32'(k_eff) * 32'(k_eff);
    row_bytes = 32'(BYTES_I) * 32'(tile_d) * 32'(padded_c)
              + 32'(BYTES_P) * 32'(tile_k) * 32'(work_out_c);
    // Saturating the divisor keeps an oversized row from wrapping into a
    // small divisor and producing a bogus large tile count.
    row_dvsr = (row_bytes > DIV_MAX) ? '1 : row_bytes[DIV_W-1:0];

    prep_err  = 1'b1;
    prep_code = 2'd0;
    if (cap_stride == 2'd0)
      prep_code = 2'd1;
    else if ((padded_r < PD_W'(k_eff)) || (padded_c < PD_W'(k_eff)))
      prep_code = 2'd2;
    else if (w_bytes >= 32'(GLB_BYTES))
      prep_code = 2'd3;
    else
      prep_err = 1'b0;
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    div_shift   = {div_rem[DIV_W-1:0], div_quo[DIV_W-1]};
    div_ge      = (div_shift >= {1'b0, div_dvsr});
    div_rem_nxt = div_ge ? (div_shift - {1'b0, div_dvsr}) : div_shift;
    div_quo_nxt = {div_quo[DIV_W-2:0], div_ge};
    div_last    = (div_cnt == CNT_W'(DIV_W - 1));

    quo_plus1    = {1'b0, div_quo_nxt} + 1'b1;
    dim_from_quo = (quo_plus1 > DIM_MAX) ? '1 : quo_plus1[DIM_W-1:0];
    tile_n_calc  = (div_quo_nxt > DIV_W'(MAX_TILE_N)) ? N_W'(MAX_TILE_N)
                                                       : N_W'(div_quo_nxt);
  end

  assign accept   = bus.in_valid_i && (state == S_IDLE) && !bus.flush_i;
  assign load_err = (state == S_PREP) && prep_err && !bus.flush_i;
  assign load_ok  = (state == S_DIV_N) && div_last && !bus.flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (bus.in_valid_i) state_n = S_PREP;
      S_PREP:  state_n = prep_err ? S_DONE : S_DIV_R;
      S_DIV_R: if (div_last) state_n = S_DIV_C;
      S_DIV_C: if (div_last) state_n = S_FOOT;
      S_FOOT:  state_n = S_DIV_N;
      S_DIV_N: if (div_last) state_n = S_DONE;
      S_DONE:  if (bus.out_ready_i) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (bus.flush_i) state_n = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_type   <= '0;  cap_k      <= '0;  cap_stride <= '0;
      cap_in_r   <= '0;  cap_in_c   <= '0;
      cap_in_d   <= '0;  cap_out_k  <= '0;
      cap_pad_t  <= '0;  cap_pad_b  <= '0;
      cap_pad_l  <= '0;  cap_pad_r  <= '0;
      cap_pass   <= '0;
      work_out_r <= '0;  work_out_c <= '0;
      div_rem    <= '0;  div_quo    <= '0;
      div_dvsr   <= '0;  div_cnt    <= '0;
    end else begin
      if (accept) begin
        cap_type   <= bus.layer_type_i;
        cap_k      <= bus.k_i;
        cap_stride <= bus.stride_i;
        cap_in_r   <= bus.in_R_i;
        cap_in_c   <= bus.in_C_i;
        cap_in_d   <= bus.in_D_i;
        cap_out_k  <= bus.out_K_i;
        cap_pad_t  <= bus.pad_T_i;
        cap_pad_b  <= bus.pad_B_i;
        cap_pad_l  <= bus.pad_L_i;
        cap_pad_r  <= bus.pad_R_i;
        cap_pass   <= bus.pass_i;
      end
      case (state)
        S_PREP: begin
          div_rem  <= '0;
          div_quo  <= DIV_W'(padded_r - PD_W'(k_eff));
          div_dvsr <= DIV_W'(cap_stride);
          div_cnt  <= '0;
        end
        S_DIV_R, S_DIV_C, S_DIV_N: begin
          div_rem <= div_rem_nxt;
          div_quo <= div_quo_nxt;
          div_cnt <= div_cnt + 1'b1;
          // The last step of the row divide immediately reloads for columns.
          if (div_last && (state == S_DIV_R)) begin
            work_out_r <= dim_from_quo;
            div_rem    <= '0;
            div_quo    <= DIV_W'(padded_c - PD_W'(k_eff));
            div_cnt    <= '0;
          end
          if (div_last && (state == S_DIV_C))
            work_out_c <= dim_from_quo;
        end
        S_FOOT: begin
          div_rem  <= '0;
          div_quo  <= DIV_W'(32'(GLB_BYTES) - w_bytes);
          div_dvsr <= row_dvsr;
          div_cnt  <= '0;
        end
        default: ;
      endcase
    end
  end

  // Result registers update only on the transition into DONE so the
  // consumer sees a coherent set that holds through IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_type     <= '0;  r_stride   <= '0;  r_k        <= '0;
      r_in_d     <= '0;  r_out_k    <= '0;
      r_pad_r    <= '0;  r_pad_c    <= '0;
      r_out_r    <= '0;  r_out_c    <= '0;
      r_tile_d   <= '0;  r_tile_k   <= '0;
      r_tile_d_f <= '0;  r_tile_k_f <= '0;
      r_tile_n   <= '0;  r_pass     <= '0;
      r_err      <= 1'b0; r_err_code <= '0;
    end else if (load_err || load_ok) begin
      r_type     <= cap_type;
      r_stride   <= cap_stride;
      r_k        <= k_eff;
      r_in_d     <= cap_in_d;
      r_out_k    <= cap_out_k;
      r_pad_r    <= padded_r;
      r_pad_c    <= padded_c;
      r_tile_d   <= tile_d;
      r_tile_k   <= tile_k;
      r_tile_d_f <= tile_d_f;
      r_tile_k_f <= tile_k_f;
      r_pass     <= cap_pass;
      if (load_err) begin
        r_out_r    <= '0;
        r_out_c    <= '0;
        r_tile_n   <= '0;
        r_err      <= 1'b1;
        r_err_code <= prep_code;
      end else begin
        r_out_r    <= work_out_r;
        r_out_c    <= work_out_c;
        r_tile_n   <= tile_n_calc;
        r_err      <= 1'b0;
        r_err_code <= 2'd0;
      end
    end
  end

  assign bus.in_ready_o   = (state == S_IDLE);
  assign bus.out_valid_o  = (state == S_DONE);
  assign bus.layer_type_o = r_type;
  assign bus.kH_o         = r_k;
  assign bus.kW_o         = r_k;
  assign bus.stride_o     = r_stride;
  assign bus.in_D_o       = r_in_d;
  assign bus.out_K_o      = r_out_k;
  assign bus.padded_R_o   = r_pad_r;
  assign bus.padded_C_o   = r_pad_c;
  assign bus.out_R_o      = r_out_r;
  assign bus.out_C_o      = r_out_c;
  assign bus.tile_D_o     = r_tile_d;
  assign bus.tile_K_o     = r_tile_k;
  assign bus.tile_D_f_o   = r_tile_d_f;
  assign bus.tile_K_f_o   = r_tile_k_f;
  assign bus.tile_n_o     = r_tile_n;
  assign bus.pass_o       = r_pass;
  assign bus.err_o        = r_err;
  assign bus.err_code_o   = r_err_code;

endmodule

// File: tb/tb_layer_desc_decoder_seq.sv
// Purpose: directed self-checking bench for layer_desc_decoder_seq with
//          hand-computed expected values for the default parameter set.
module tb_layer_desc_decoder_seq;

  localparam logic [139:0] PASS_A = {4'hA, {17{8'h5C}}};
  localparam logic [139:0] PASS_B = {4'h3, {17{8'hC3}}};
  localparam logic [139:0] PASS_C = {4'h9, {34{4'h1}}};

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;
  int   lat;
  logic seen;

  layer_desc_decoder_seq_if intf ();

  layer_desc_decoder_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (intf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [159:0] obs,
                             input logic [159:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] ty, input logic [2:0] k,
                               input logic [1:0] s, input logic [7:0] r,
                               input logic [7:0] c, input logic [10:0] d,
                               input logic [10:0] kk, input logic [1:0] pad,
                               input logic [139:0] pass);
    intf.layer_type_i = ty;
    intf.k_i          = k;
    intf.stride_i     = s;
    intf.in_R_i       = r;
    intf.in_C_i       = c;
    intf.in_D_i       = d;
    intf.out_K_i      = kk;
    intf.pad_T_i      = pad;
    intf.pad_B_i      = pad;
    intf.pad_L_i      = pad;
    intf.pad_R_i      = pad;
    intf.pass_i       = pass;
    intf.in_valid_i   = 1'b1;
  endtask

  task automatic acceptOne();
    @(posedge clk);
    #1 intf.in_valid_i = 1'b0;
  endtask

  // Counts cycles after the capture edge until out_valid, bounded.
  task automatic waitValid(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!intf.out_valid_o && cycles < 200);
  endtask

  task automatic checkResult(input string tag, input int pr, input int pc,
                             input int orr, input int oc, input int k,
                             input int td, input int tk, input int tdf,
                             input int tkf, input int tn, input int err,
                             input int code);
    checkOutput({tag, ".valid"},    160'(intf.out_valid_o), 160'(1));
    checkOutput({tag, ".padded_R"}, 160'(intf.padded_R_o),  160'(pr));
    checkOutput({tag, ".padded_C"}, 160'(intf.padded_C_o),  160'(pc));
    checkOutput({tag, ".out_R"},    160'(intf.out_R_o),     160'(orr));
    checkOutput({tag, ".out_C"},    160'(intf.out_C_o),     160'(oc));
    checkOutput({tag, ".kH"},       160'(intf.kH_o),        160'(k));
    checkOutput({tag, ".kW"},       160'(intf.kW_o),        160'(k));
    checkOutput({tag, ".tile_D"},   160'(intf.tile_D_o),    160'(td));
    checkOutput({tag, ".tile_K"},   160'(intf.tile_K_o),    160'(tk));
    checkOutput({tag, ".tile_D_f"}, 160'(intf.tile_D_f_o),  160'(tdf));
    checkOutput({tag, ".tile_K_f"}, 160'(intf.tile_K_f_o),  160'(tkf));
    checkOutput({tag, ".tile_n"},   160'(intf.tile_n_o),    160'(tn));
    checkOutput({tag, ".err"},      160'(intf.err_o),       160'(err));
    checkOutput({tag, ".err_code"}, 160'(intf.err_code_o),  160'(code));
  endtask

  task automatic handoff(input string tag);
    intf.out_ready_i = 1'b1;
    @(posedge clk);
    #1 intf.out_ready_i = 1'b0;
    @(negedge clk);
    checkOutput({tag, ".valid_drop"}, 160'(intf.out_valid_o), 160'(0));
    checkOutput({tag, ".ready_back"}, 160'(intf.in_ready_o),  160'(1));
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    intf.flush_i     = 1'b0;
    intf.in_valid_i  = 1'b0;
    intf.out_ready_i = 1'b0;
    applyStimulus(2'd0, 3'd0, 2'd0, 8'd0, 8'd0, 11'd0, 11'd0, 2'd0, '0);
    intf.in_valid_i = 1'b0;

    #12;
    checkOutput("reset.in_ready",  160'(intf.in_ready_o),  160'(1));
    checkOutput("reset.out_valid", 160'(intf.out_valid_o), 160'(0));
    checkOutput("reset.tile_n",    160'(intf.tile_n_o),    160'(0));
    checkOutput("reset.pass",      160'(intf.pass_o),      160'(0));
    checkOutput("reset.err",       160'(intf.err_o),       160'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // PW 56x56, pad 0, stride 1, D=64, K=128
    @(negedge clk);
    applyStimulus(2'd0, 3'd5, 2'd1, 8'd56, 8'd56, 11'd64, 11'd128, 2'd0, PASS_A);
    acceptOne();
    waitValid(lat);
    checkOutput("pw56.latency", 160'(lat), 160'(75));
    checkResult("pw56", 56, 56, 56, 56, 1, 32, 32, 32, 32, 12, 0, 0);
    checkOutput("pw56.in_D",   160'(intf.in_D_o),       160'(64));
    checkOutput("pw56.out_K",  160'(intf.out_K_o),      160'(128));
    checkOutput("pw56.stride", 160'(intf.stride_o),     160'(1));
    checkOutput("pw56.type",   160'(intf.layer_type_o), 160'(0));
    checkOutput("pw56.pass",   160'(intf.pass_o),       160'(PASS_A));
    handoff("pw56");

    // DW 112x112, pad 1, stride 2, k=3
    @(negedge clk);
    applyStimulus(2'd1, 3'd3, 2'd2, 8'd112, 8'd112, 11'd32, 11'd32, 2'd1, PASS_B);
    acceptOne();
    waitValid(lat);
    checkOutput("dw112.latency", 160'(lat), 160'(75));
    checkResult("dw112", 114, 114, 56, 56, 3, 10, 10, 1, 10, 28, 0, 0);
    checkOutput("dw112.type", 160'(intf.layer_type_o), 160'(1));
    handoff("dw112");

    // PW 1x1: raw quotient 672 clamps to 255, outputs hold while stalled
    @(negedge clk);
    applyStimulus(2'd0, 3'd0, 2'd1, 8'd1, 8'd1, 11'd8, 11'd8, 2'd0, PASS_C);
    acceptOne();
    waitValid(lat);
    checkResult("pw1", 1, 1, 1, 1, 1, 32, 32, 32, 32, 255, 0, 0);
    repeat (10) @(negedge clk);
    checkOutput("pw1.hold_valid",  160'(intf.out_valid_o), 160'(1));
    checkOutput("pw1.hold_tile_n", 160'(intf.tile_n_o),    160'(255));
    checkOutput("pw1.hold_out_R",  160'(intf.out_R_o),     160'(1));
    checkOutput("pw1.hold_pass",   160'(intf.pass_o),      160'(PASS_C));
    handoff("pw1");

    // DW 2x2, k=5: kernel larger than padded dims
    @(negedge clk);
    applyStimulus(2'd1, 3'd5, 2'd1, 8'd2, 8'd2, 11'd4, 11'd4, 2'd0, PASS_A);
    acceptOne();
    waitValid(lat);
    checkOutput("err2.latency", 160'(lat), 160'(2));
    checkResult("err2", 2, 2, 0, 0, 5, 10, 10, 1, 10, 0, 1, 2);
    handoff("err2");

    // Same with stride 0: stride error has priority
    @(negedge clk);
    applyStimulus(2'd1, 3'd5, 2'd0, 8'd2, 8'd2, 11'd4, 11'd4, 2'd0, PASS_A);
    acceptOne();
    waitValid(lat);
    checkOutput("err1.latency", 160'(lat), 160'(2));
    checkResult("err1", 2, 2, 0, 0, 5, 10, 10, 1, 10, 0, 1, 1);
    checkOutput("err1.stride", 160'(intf.stride_o), 160'(0));
    handoff("err1");

    // Flush in the middle of the column divide
    @(negedge clk);
    applyStimulus(2'd2, 3'd3, 2'd1, 8'd32, 8'd32, 11'd16, 11'd16, 2'd1, PASS_B);
    acceptOne();
    repeat (35) @(negedge clk);
    intf.flush_i = 1'b1;
    @(posedge clk);
    #1 intf.flush_i = 1'b0;
    @(negedge clk);
    checkOutput("flush.in_ready",  160'(intf.in_ready_o),  160'(1));
    checkOutput("flush.out_valid", 160'(intf.out_valid_o), 160'(0));
    seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (intf.out_valid_o) seen = 1'b1;
    end
    checkOutput("flush.no_result", 160'(seen), 160'(0));

    // Flush and valid together in IDLE: nothing is captured
    applyStimulus(2'd2, 3'd3, 2'd1, 8'd32, 8'd32, 11'd16, 11'd16, 2'd1, PASS_B);
    intf.flush_i = 1'b1;
    @(posedge clk);
    #1;
    intf.flush_i    = 1'b0;
    intf.in_valid_i = 1'b0;
    @(negedge clk);
    checkOutput("flushvalid.in_ready", 160'(intf.in_ready_o), 160'(1));

    // STD 32x32, pad 1, k=3, stride 1 after the flush
    applyStimulus(2'd2, 3'd3, 2'd1, 8'd32, 8'd32, 11'd16, 11'd16, 2'd1, PASS_B);
    acceptOne();
    waitValid(lat);
    checkOutput("std32.latency", 160'(lat), 160'(75));
    checkResult("std32", 34, 34, 32, 32, 3, 10, 10, 10, 10, 65, 0, 0);
    checkOutput("std32.pass", 160'(intf.pass_o), 160'(PASS_B));
    handoff("std32");

    // Back-to-back with out_ready held high; second is LIN (k_i ignored)
    intf.out_ready_i = 1'b1;
    @(negedge clk);
    applyStimulus(2'd0, 3'd0, 2'd1, 8'd56, 8'd56, 11'd64, 11'd128, 2'd0, PASS_A);
    @(posedge clk);
    #1 applyStimulus(2'd3, 3'd7, 2'd1, 8'd4, 8'd4, 11'd9, 11'd9, 2'd0, PASS_C);
    waitValid(lat);
    checkOutput("b2b1.latency", 160'(lat), 160'(75));
    checkOutput("b2b1.tile_n",  160'(intf.tile_n_o), 160'(12));
    @(negedge clk);
    checkOutput("b2b.gap_valid", 160'(intf.out_valid_o), 160'(0));
    checkOutput("b2b.gap_ready", 160'(intf.in_ready_o),  160'(1));
    acceptOne();
    waitValid(lat);
    checkOutput("b2b2.latency", 160'(lat), 160'(75));
    checkResult("b2b2", 4, 4, 4, 4, 1, 32, 32, 32, 32, 168, 0, 0);
    checkOutput("b2b2.type", 160'(intf.layer_type_o), 160'(3));
    @(negedge clk);
    intf.out_ready_i = 1'b0;

    // Reset asserted in the middle of the tile-count divide
    applyStimulus(2'd0, 3'd0, 2'd1, 8'd56, 8'd56, 11'd64, 11'd128, 2'd0, PASS_A);
    acceptOne();
    repeat (60) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst.out_valid", 160'(intf.out_valid_o),  160'(0));
    checkOutput("rst.in_ready",  160'(intf.in_ready_o),   160'(1));
    checkOutput("rst.tile_n",    160'(intf.tile_n_o),     160'(0));
    checkOutput("rst.out_R",     160'(intf.out_R_o),      160'(0));
    checkOutput("rst.type",      160'(intf.layer_type_o), 160'(0));
    checkOutput("rst.kH",        160'(intf.kH_o),         160'(0));
    checkOutput("rst.tile_D",    160'(intf.tile_D_o),     160'(0));
    checkOutput("rst.pass",      160'(intf.pass_o),       160'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
